conv_maxpool_engine: RTL and testbench

Parametrised successor to the fixed 4-tap, 6-bit convolution/max block. It serially loads TAPS weights and TAPS activations into shift registers, then computes their dot product with one time-shared multiply-accumulate per cycle. It max-pools POOL consecutive dot products and presents each pooled result on a valid/ready output. It sits between the pin-level input deserialiser and the output muxing in the top-level wrapper.

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_mac.sv | 44 ++++
 rtl/conv_maxpool_engine.sv | 125 ++++++++++++
 tb/tb_conv_maxpool_engine.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution / max-pool engine.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    CMP  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Headroom of $clog2(taps) bits keeps a full-scale dot product from wrapping.
  function automatic int acc_width(input int data_w, input int taps);
    return 2 * data_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Time-shared multiply-accumulate for the dot product.
// CONV_SIGNED_EN selects two's-complement operands; otherwise products are unsigned.
module conv_mac #(
  parameter int DATA_W = 6,
  parameter int ACC_W  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prod_ext;

  // Operands are widened before multiplying so the low PROD_W bits are the exact product.
`ifdef CONV_SIGNED_EN
  assign a_ext    = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_ext    = {{DATA_W{b[DATA_W-1]}}, b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
`else
  assign a_ext    = {{DATA_W{1'b0}}, a};
  assign b_ext    = {{DATA_W{1'b0}}, b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W - PROD_W){1'b0}}, prod};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= (clear ? '0 : acc) + prod_ext;
    end
  end

endmodule

// File: rtl/conv_maxpool_engine.sv
// Serial-load dot-product engine with POOL-deep max-pooling and a valid/ready result port.
// CONV_SIGNED_EN switches operands, accumulation and the max compare to two's complement.
module conv_maxpool_engine
  import conv_pkg::*;
#(
  parameter  int DATA_W = 6,
  parameter  int TAPS   = 4,
  parameter  int POOL   = 4,
  localparam int ACC_W  = acc_width(DATA_W, TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_weight,
  input  logic [DATA_W-1:0] in_data,
  input  logic              start,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data
);

  localparam int CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int POOL_W = (POOL > 1) ? $clog2(POOL) : 1;
  localparam logic [CNT_W-1:0]  MAC_LAST  = CNT_W'(TAPS - 1);
  localparam logic [POOL_W-1:0] POOL_LAST = POOL_W'(POOL - 1);

  state_t             state;
  state_t             state_next;
  logic [DATA_W-1:0]  w_reg   [TAPS];
  logic [DATA_W-1:0]  act_reg [TAPS];
  logic [CNT_W-1:0]   mac_cnt;
  logic [POOL_W-1:0]  pool_cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   max_reg;
  logic               acc_gt;
  logic               load_fire;

  assign in_ready  = (state == IDLE) && !start;
  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);
  assign out_data  = max_reg;
  assign load_fire = in_valid && in_ready;

`ifdef CONV_SIGNED_EN
  assign acc_gt = $signed(acc) > $signed(max_reg);
`else
  assign acc_gt = acc > max_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MAC;
      MAC:     if (mac_cnt == MAC_LAST) state_next = CMP;
      CMP:     state_next = (pool_cnt == POOL_LAST) ? OUT : IDLE;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mac_cnt <= '0;
    end else if (state == MAC) begin
      mac_cnt <= (mac_cnt == MAC_LAST) ? '0 : mac_cnt + CNT_W'(1);
    end else begin
      mac_cnt <= '0;
    end
  end

  // Newest beat enters at the top; tap 0 always holds the oldest retained beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        w_reg[i]   <= '0;
        act_reg[i] <= '0;
      end
    end else if (load_fire) begin
      if (in_is_weight) begin
        for (int i = 0; i < TAPS - 1; i++) w_reg[i] <= w_reg[i+1];
        w_reg[TAPS-1] <= in_data;
      end else begin
        for (int i = 0; i < TAPS - 1; i++) act_reg[i] <= act_reg[i+1];
        act_reg[TAPS-1] <= in_data;
      end
    end
  end

  // The first result of a window loads unconditionally so negative maxima survive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pool_cnt <= '0;
      max_reg  <= '0;
    end else if (state == CMP) begin
      if ((pool_cnt == '0) || acc_gt) max_reg <= acc;
      pool_cnt <= (pool_cnt == POOL_LAST) ? '0 : pool_cnt + POOL_W'(1);
    end else if ((state == OUT) && out_ready) begin
      max_reg <= '0;
    end
  end

  conv_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (mac_cnt == '0),
    .en    (state == MAC),
    .a     (act_reg[mac_cnt]),
    .b     (w_reg[mac_cnt]),
    .acc   (acc)
  );

endmodule

// File: tb/tb_conv_maxpool_engine.sv
// Self-checking bench for conv_maxpool_engine against a behavioural dot-product / max-pool model.
module tb_conv_maxpool_engine;

  localparam int DATA_W = 6;
  localparam int TAPS   = 4;
  localparam int POOL   = 4;
  localparam int ACC_W  = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_is_weight = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic              in_ready;
  logic              busy;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;

  int vectors = 0;
  int miscompares = 0;

  int w_m [TAPS];
  int a_m [TAPS];
  int window [$];
  bit win_done;
  logic [ACC_W-1:0] exp_out;

  conv_maxpool_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_is_weight (in_is_weight),
    .in_data      (in_data),
    .start        (start),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int opv(input logic [DATA_W-1:0] d);
    int v;
`ifdef CONV_SIGNED_EN
    v = $signed(d);
`else
    v = int'(d);
`endif
    return v;
  endfunction

  function automatic int dotModel();
    int s = 0;
    for (int i = 0; i < TAPS; i++) s += a_m[i] * w_m[i];
    return s;
  endfunction

  function automatic void clearModel();
    for (int i = 0; i < TAPS; i++) begin
      w_m[i] = 0;
      a_m[i] = 0;
    end
    window.delete();
  endfunction

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();
  endtask

  task automatic applyStimulus(input bit is_w, input logic [DATA_W-1:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_is_weight = is_w;
    in_data = d;
    #1;
    checkOutput("load_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (is_w) begin
      for (int i = 0; i < TAPS - 1; i++) w_m[i] = w_m[i+1];
      w_m[TAPS-1] = opv(d);
    end else begin
      for (int i = 0; i < TAPS - 1; i++) a_m[i] = a_m[i+1];
      a_m[TAPS-1] = opv(d);
    end
  endtask

  task automatic loadSet(input bit is_w, input int v0, input int v1, input int v2, input int v3);
    applyStimulus(is_w, DATA_W'(v0));
    applyStimulus(is_w, DATA_W'(v1));
    applyStimulus(is_w, DATA_W'(v2));
    applyStimulus(is_w, DATA_W'(v3));
  endtask

  task automatic startDot(input bit collide);
    int lat;
    int m;
    @(negedge clk);
    start = 1'b1;
    if (collide) begin
      in_valid = 1'b1;
      in_is_weight = 1'($urandom_range(0, 1));
      in_data = DATA_W'($urandom);
      #1;
      checkOutput("collide_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
    lat = 0;
    while ((busy === 1'b1) && (out_valid !== 1'b1) && (lat < 20)) begin
      @(posedge clk);
      #1;
      lat++;
    end
    window.push_back(dotModel());
    win_done = (window.size() == POOL);
    if (win_done) begin
      m = window[0];
      for (int i = 1; i < POOL; i++) if (window[i] > m) m = window[i];
      exp_out = ACC_W'(m);
      window.delete();
    end
    checkOutput("latency", lat, TAPS + 1);
    checkOutput("out_valid", out_valid, {31'd0, win_done});
    checkOutput("busy_after", busy, {31'd0, win_done});
    if (win_done) checkOutput("out_data", out_data, exp_out);
  endtask

  task automatic drainResult(input int stall);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_is_weight = 1'($urandom_range(0, 1));
      in_data = DATA_W'($urandom);
      #1;
      checkOutput("out_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_data", out_data, exp_out);
    end
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("post_valid", out_valid, 0);
    checkOutput("post_busy", busy, 0);
    checkOutput("max_cleared", out_data, 0);
  endtask

  task automatic runDot(input bit collide, input int stall);
    startDot(collide);
    if (win_done) drainResult(stall);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearModel();
    resetDut();

    // Basic dot product: 1*1+2*1+3*1+4*1, four times into one window.
    loadSet(1'b1, 1, 2, 3, 4);
    loadSet(1'b0, 1, 1, 1, 1);
    for (int i = 0; i < POOL; i++) runDot(1'b0, 0);

    // Window 5, full-scale, 7, 0 with a long stall on the result.
    loadSet(1'b0, 1, 0, 0, 1);
    runDot(1'b0, 0);
    loadSet(1'b1, 63, 63, 63, 63);
    loadSet(1'b0, 63, 63, 63, 63);
    runDot(1'b0, 0);
    loadSet(1'b1, 1, 2, 3, 4);
    loadSet(1'b0, 0, 2, 1, 0);
    runDot(1'b0, 0);
    loadSet(1'b0, 0, 0, 0, 0);
    runDot(1'b0, 6);

    // Equal results: the max register must have been cleared.
    loadSet(1'b0, 3, 0, 0, 0);
    for (int i = 0; i < POOL; i++) runDot(1'b0, 1);

    // Start and load in the same cycle; the beat must be dropped.
    loadSet(1'b0, 2, 5, 7, 1);
    for (int i = 0; i < POOL; i++) runDot(1'b1, 0);

    // Reset in the middle of a MAC after two window results.
    runDot(1'b0, 0);
    runDot(1'b0, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();
    loadSet(1'b1, 9, 8, 7, 6);
    loadSet(1'b0, 1, 2, 3, 4);
    for (int i = 0; i < POOL; i++) runDot(1'b0, 0);

`ifdef CONV_SIGNED_EN
    // All-negative window: weights -1 against positive activations.
    loadSet(1'b1, 63, 63, 63, 63);
    loadSet(1'b0, 1, 1, 1, 1);
    runDot(1'b0, 0);
    loadSet(1'b0, 2, 2, 2, 2);
    runDot(1'b0, 0);
    loadSet(1'b0, 1, 1, 0, 0);
    runDot(1'b0, 0);
    loadSet(1'b0, 2, 1, 1, 2);
    runDot(1'b0, 2);
    checkOutput("signed_neg_max", exp_out, 14'h3FFE);
`endif

    // Randomised loads, collisions and backpressure.
    for (int n = 0; n < 6 * POOL; n++) begin
      int beats;
      beats = $urandom_range(0, 5);
      for (int b = 0; b < beats; b++) applyStimulus(1'($urandom_range(0, 1)), DATA_W'($urandom));
      runDot(($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
